axil_regbank: RTL and testbench

Parametrised AXI4-Lite slave with an integrated register file.
- Replaces the fixed three-register config block.
- Each of NUM_REGS word registers has a selectable access mode: RW, RO-status, W1C or self-clearing pulse.
- Decodes its own address window and returns SLVERR on bad accesses.
- Sits between the interconnect and cache/control logic. It exports register values and write strobes, and imports status and event bits.

---
 rtl/axil_regbank_pkg.sv | 17 +
 rtl/axil_reg_cell.sv | 60 ++++++
 rtl/axil_regbank.sv | 206 ++++++++++++++++++++
 tb/tb_axil_regbank.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_regbank_pkg.sv
// Shared constants and state types for the AXI4-Lite register bank.
package axil_regbank_pkg;

  localparam logic [1:0] MODE_RW    = 2'd0;
  localparam logic [1:0] MODE_RO    = 2'd1;
  localparam logic [1:0] MODE_W1C   = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] BAD_DATA_DEFAULT = 32'h0000_0BAD;

  typedef enum logic [1:0] {WrIdle, WrExec, WrResp} wr_state_e;
  typedef enum logic {RdIdle, RdResp} rd_state_e;

endpackage

// File: rtl/axil_reg_cell.sv
// One register word of the bank; MODE selects RW, RO, W1C or self-clearing pulse behaviour.
module axil_reg_cell
  import axil_regbank_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [1:0]        MODE      = MODE_RW,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   status_in,
  output logic [DATA_W-1:0]   value
);

  localparam logic [DATA_W-1:0] INIT_VAL = (MODE == MODE_RW) ? RESET_VAL : '0;

  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] value_q, value_d;

  always_comb begin
    mask = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      mask[b*8 +: 8] = {8{wstrb[b]}};
    end
  end

  always_comb begin
    value_d = value_q;
    case (MODE)
      MODE_RW: begin
        if (wr_en) value_d = (value_q & ~mask) | (wdata & mask);
      end
      MODE_W1C: begin
        if (wr_en) value_d = value_q & ~(wdata & mask);
        // Hardware set is applied last so it beats a same-cycle software clear.
        value_d = value_d | status_in;
      end
      MODE_PULSE: begin
        value_d = wr_en ? (wdata & mask) : '0;
      end
      default: begin
        value_d = '0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      value_q <= INIT_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = (MODE == MODE_RO) ? status_in : value_q;

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite slave with a parametrised register file and independent read/write paths.
// Optional interrupt output enabled by defining AXIL_REGBANK_IRQ_EN.
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int unsigned                 ADDR_W     = 32,
  parameter int unsigned                 DATA_W     = 32,
  parameter int unsigned                 NUM_REGS   = 4,
  parameter logic [ADDR_W-1:0]           BASE_ADDR  = ADDR_W'(32'h1000_0000),
  parameter logic [2*NUM_REGS-1:0]       REG_MODES  = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VALS = '0,
  parameter logic [DATA_W-1:0]           BAD_DATA   = DATA_W'(BAD_DATA_DEFAULT)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [ADDR_W-1:0]            s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_W-1:0]            s_axi_wdata,
  input  logic [DATA_W/8-1:0]          s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_W-1:0]            s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr,
  input  logic [NUM_REGS*DATA_W-1:0]   status_in
`ifdef AXIL_REGBANK_IRQ_EN
  ,
  output logic                         irq
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  function automatic logic dec_err(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return (addr < BASE_ADDR) || ((addr & ADDR_W'(STRB_W - 1)) != '0) ||
           ((off >> LSB) >= ADDR_W'(NUM_REGS));
  endfunction

  function automatic logic [IDX_W-1:0] dec_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = (addr - BASE_ADDR) >> LSB;
    return off[IDX_W-1:0];
  endfunction

  logic [DATA_W-1:0] reg_val [NUM_REGS];

  // Write path
  wr_state_e         wr_state_q, wr_state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_hs, w_hs;
  logic              wr_err;
  logic [IDX_W-1:0]  wr_idx;

  assign s_axi_awready = (wr_state_q == WrIdle) && !aw_held_q;
  assign s_axi_wready  = (wr_state_q == WrIdle) && !w_held_q;
  assign aw_hs         = s_axi_awvalid && s_axi_awready;
  assign w_hs          = s_axi_wvalid && s_axi_wready;
  assign wr_err        = dec_err(awaddr_q);
  assign wr_idx        = dec_idx(awaddr_q);

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    case (wr_state_q)
      WrIdle: begin
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        if (aw_held_d && w_held_d) wr_state_d = WrExec;
      end
      WrExec: wr_state_d = WrResp;
      WrResp: begin
        if (s_axi_bready) begin
          wr_state_d = WrIdle;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state_q <= WrIdle;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
    end
  end

  always_comb begin
    reg_wr = '0;
    if (wr_state_q == WrExec && !wr_err) reg_wr[wr_idx] = 1'b1;
  end

  assign s_axi_bvalid = (wr_state_q == WrResp);
  assign s_axi_bresp  = (s_axi_bvalid && wr_err) ? RESP_SLVERR : RESP_OKAY;

  // Read path; capture happens on the AR edge, so a same-cycle write is not yet visible.
  rd_state_e         rd_state_q, rd_state_d;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              ar_hs;
  logic              rd_err;
  logic [IDX_W-1:0]  rd_idx;

  assign s_axi_arready = (rd_state_q == RdIdle);
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign rd_err        = dec_err(s_axi_araddr);
  assign rd_idx        = dec_idx(s_axi_araddr);

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RdIdle:  if (ar_hs) rd_state_d = RdResp;
      RdResp:  if (s_axi_rready) rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state_q <= RdIdle;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      if (ar_hs) begin
        rdata_q <= rd_err ? BAD_DATA : reg_val[rd_idx];
        rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign s_axi_rvalid = (rd_state_q == RdResp);
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;

  // Register cells
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    axil_reg_cell #(
      .DATA_W    (DATA_W),
      .MODE      (REG_MODES[2*i +: 2]),
      .RESET_VAL (RESET_VALS[i*DATA_W +: DATA_W])
    ) u_cell (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .wr_en     (reg_wr[i]),
      .wstrb     (wstrb_q),
      .wdata     (wdata_q),
      .status_in (status_in[i*DATA_W +: DATA_W]),
      .value     (reg_val[i])
    );
    assign reg_q[i*DATA_W +: DATA_W] = reg_val[i];
  end

`ifdef AXIL_REGBANK_IRQ_EN
  logic [NUM_REGS-1:0] w1c_any;
  logic                irq_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_irq
    assign w1c_any[i] = (REG_MODES[2*i +: 2] == MODE_W1C) && (|reg_val[i]);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |w1c_any;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_axil_regbank.sv
// Directed bench for axil_regbank: reg0 PULSE, reg1 RW, reg2 W1C, reg3 RO.
module tb_axil_regbank;
  import axil_regbank_pkg::*;

  localparam int unsigned    NUM_REGS = 4;
  localparam logic [7:0]     MODES    = 8'h63;
  localparam logic [127:0]   RVALS    = {32'h0000_0000, 32'h0000_00F0,
                                         32'h0000_0000, 32'hFFFF_FFFF};
  localparam logic [31:0]    RO_STAT  = 32'hCAFE_F00D;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [31:0]   awaddr, wdata, araddr;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [127:0]  reg_q, status_in;
  logic [3:0]    reg_wr;
`ifdef AXIL_REGBANK_IRQ_EN
  logic          irq;
`endif

  int checks = 0;
  int failures = 0;
  int wr_cnt [NUM_REGS];
  int pulse_cycles = 0;
  logic [31:0] pulse_val = '0;

  always #5 aclk = ~aclk;

  axil_regbank #(
    .REG_MODES  (MODES),
    .RESET_VALS (RVALS)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .reg_q         (reg_q),
    .reg_wr        (reg_wr),
    .status_in     (status_in)
`ifdef AXIL_REGBANK_IRQ_EN
    , .irq         (irq)
`endif
  );

  initial for (int i = 0; i < NUM_REGS; i++) wr_cnt[i] = 0;

  // Counts cycles, sampled at the closing edge of each cycle.
  always @(posedge aclk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_wr[i] === 1'b1) wr_cnt[i] <= wr_cnt[i] + 1;
    end
    if (reg_q[31:0] !== 32'h0 && aresetn === 1'b1) begin
      pulse_cycles <= pulse_cycles + 1;
      pulse_val    <= reg_q[31:0];
    end
  end

  function automatic logic [31:0] regv(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // W is presented w_lead cycles before AW; returns cycles from handshake-done to bvalid.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead,
                          output logic [1:0] resp, output int lat);
    int  t = 0;
    bit  aw_done = 0, w_done = 0, aw_hs, w_hs;
    @(negedge aclk);
    while (!(aw_done && w_done) && t < 50) begin
      if (!w_done) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
      if (!aw_done && t >= w_lead) begin awaddr = addr; awvalid = 1'b1; end
      w_hs  = wvalid && wready;
      aw_hs = awvalid && awready;
      @(negedge aclk);
      t++;
      if (w_hs)  begin w_done = 1; wvalid = 1'b0; end
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
    end
    check("wr addr/data accepted", 32'(aw_done && w_done), 32'd1);
    lat = 0;
    while (!bvalid && lat < 20) begin @(negedge aclk); lat++; end
    resp = bresp;
    @(negedge aclk);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int t = 0;
    @(negedge aclk);
    araddr  = addr;
    arvalid = 1'b1;
    while (!arready && t < 20) begin @(negedge aclk); t++; end
    @(negedge aclk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin @(negedge aclk); lat++; end
    data = rdata;
    resp = rresp;
    @(negedge aclk);
  endtask

  typedef struct packed {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] d;
  logic [1:0]  r;
  int          lat;
  int          base_cnt;

  initial begin
    vecs[0]  = '{1'b0, 32'h1000_0000, 32'h0,         4'h0, RESP_OKAY,   32'h0};
    vecs[1]  = '{1'b0, 32'h1000_0004, 32'h0,         4'h0, RESP_OKAY,   32'h0};
    vecs[2]  = '{1'b0, 32'h1000_0008, 32'h0,         4'h0, RESP_OKAY,   32'h0};
    vecs[3]  = '{1'b0, 32'h1000_000C, 32'h0,         4'h0, RESP_OKAY,   RO_STAT};
    vecs[4]  = '{1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 32'h0};
    vecs[5]  = '{1'b1, 32'h1000_0002, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 32'h0};
    vecs[6]  = '{1'b1, 32'h0FFF_FFFC, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 32'h0};
    vecs[7]  = '{1'b0, 32'h1000_0010, 32'h0,         4'h0, RESP_SLVERR, 32'h0000_0BAD};
    vecs[8]  = '{1'b0, 32'h1000_0002, 32'h0,         4'h0, RESP_SLVERR, 32'h0000_0BAD};
    vecs[9]  = '{1'b0, 32'h0FFF_FFFC, 32'h0,         4'h0, RESP_SLVERR, 32'h0000_0BAD};
    vecs[10] = '{1'b1, 32'h1000_000C, 32'h1234_5678, 4'hF, RESP_OKAY,   32'h0};
    vecs[11] = '{1'b0, 32'h1000_000C, 32'h0,         4'h0, RESP_OKAY,   RO_STAT};

    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    status_in = '0;
    status_in[96 +: 32] = RO_STAT;
    repeat (3) @(negedge aclk);

    check("rst awready", 32'(awready), 32'd1);
    check("rst wready", 32'(wready), 32'd1);
    check("rst arready", 32'(arready), 32'd1);
    check("rst bvalid", 32'(bvalid), 32'd0);
    check("rst rvalid", 32'(rvalid), 32'd0);
    check("rst bresp", 32'(bresp), 32'd0);
    check("rst rresp", 32'(rresp), 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst reg_wr", 32'(reg_wr), 32'd0);
    check("rst reg0 pulse ignores reset image", regv(0), 32'd0);
    check("rst reg1", regv(1), 32'd0);
    check("rst reg2 w1c ignores reset image", regv(2), 32'd0);
`ifdef AXIL_REGBANK_IRQ_EN
    check("rst irq", 32'(irq), 32'd0);
`endif
    aresetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, r, lat);
        check($sformatf("vec%0d bresp", i), 32'(r), 32'(vecs[i].resp));
        check($sformatf("vec%0d b latency", i), 32'(lat), 32'd1);
      end else begin
        do_read(vecs[i].addr, d, r, lat);
        check($sformatf("vec%0d rdata", i), d, vecs[i].rdata);
        check($sformatf("vec%0d rresp", i), 32'(r), 32'(vecs[i].resp));
        check($sformatf("vec%0d r latency", i), 32'(lat), 32'd0);
      end
    end
    check("err writes leave reg0", regv(0), 32'd0);
    check("err writes leave reg1", regv(1), 32'd0);
    check("err writes leave reg2", regv(2), 32'd0);
    check("reg_wr0 count", 32'(wr_cnt[0]), 32'd0);
    check("reg_wr1 count", 32'(wr_cnt[1]), 32'd0);
    check("reg_wr2 count", 32'(wr_cnt[2]), 32'd0);
    check("reg_wr3 ro write pulse", 32'(wr_cnt[3]), 32'd1);

    // W leads AW by 3 cycles, byte strobes 0 and 2
    do_write(32'h1000_0004, 32'hA5A5_A5A5, 4'b0101, 3, r, lat);
    check("wfirst bresp", 32'(r), 32'(RESP_OKAY));
    check("wfirst latency", 32'(lat), 32'd1);
    check("wfirst reg1", regv(1), 32'h00A5_00A5);
    check("wfirst reg_wr1 count", 32'(wr_cnt[1]), 32'd1);
    do_read(32'h1000_0004, d, r, lat);
    check("wfirst readback", d, 32'h00A5_00A5);

    // W1C register 2, bit 3
    @(negedge aclk);
    status_in[67] = 1'b1;
    @(negedge aclk);
    status_in[67] = 1'b0;
    check("w1c hw set", regv(2), 32'h8);
`ifdef AXIL_REGBANK_IRQ_EN
    check("irq lags set", 32'(irq), 32'd0);
`endif
    @(negedge aclk);
`ifdef AXIL_REGBANK_IRQ_EN
    check("irq after set", 32'(irq), 32'd1);
`endif
    awaddr = 32'h1000_0008; awvalid = 1'b1; wdata = 32'h8; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("w1c exec reg_wr", 32'(reg_wr), 32'h4);
    status_in[67] = 1'b1;
    @(negedge aclk);
    status_in[67] = 1'b0;
    check("w1c set beats clear", regv(2), 32'h8);
    check("w1c collide bvalid", 32'(bvalid), 32'd1);
    @(negedge aclk);
    do_write(32'h1000_0008, 32'h8, 4'hF, 0, r, lat);
    check("w1c sw clear", regv(2), 32'h0);
`ifdef AXIL_REGBANK_IRQ_EN
    check("irq after clear", 32'(irq), 32'd0);
`endif

    // PULSE register 0, only byte 0 strobed
    base_cnt = pulse_cycles;
    do_write(32'h1000_0000, 32'hFFFF_FF01, 4'b0001, 0, r, lat);
    repeat (2) @(negedge aclk);
    check("pulse cycles", 32'(pulse_cycles - base_cnt), 32'd1);
    check("pulse value", pulse_val, 32'h1);
    do_read(32'h1000_0000, d, r, lat);
    check("pulse readback", d, 32'h0);

    // Stalled B with concurrent read landing on the write's update edge
    bready = 1'b0;
    @(negedge aclk);
    awaddr = 32'h1000_0004; awvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h1000_0004; arvalid = 1'b1;
    check("stall arready", 32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    check("stall rvalid", 32'(rvalid), 32'd1);
    check("read sees pre-write", rdata, 32'h00A5_00A5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d bvalid", k), 32'(bvalid), 32'd1);
      check($sformatf("stall%0d awready", k), 32'(awready), 32'd0);
      check($sformatf("stall%0d wready", k), 32'(wready), 32'd0);
      @(negedge aclk);
    end
    check("stall bresp", 32'(bresp), 32'(RESP_OKAY));
    bready = 1'b1;
    @(negedge aclk);
    check("stall released bvalid", 32'(bvalid), 32'd0);
    check("stall released awready", 32'(awready), 32'd1);
    do_read(32'h1000_0004, d, r, lat);
    check("post-stall reg1", d, 32'h1234_5678);

    // Reset with an AW held
    @(negedge aclk);
    awaddr = 32'h1000_0004; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    check("aw held awready", 32'(awready), 32'd0);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    check("midrst awready", 32'(awready), 32'd1);
    check("midrst reg1", regv(1), 32'h0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midrst%0d bvalid", k), 32'(bvalid), 32'd0);
      @(negedge aclk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
